squid_burst_collector: RTL and testbench

Upstream front-end of the SQUID decoder. It accepts one codeword as a burst of narrow beats from the memory-side interface and assembles a 64-bit frame. It splits the frame into eight 6-bit data symbols and four 4-bit parity nibbles, which feed the syndrome generator directly. A one-entry output register with a valid/ready handshake decouples the burst source from decoder back-pressure, and malformed bursts are flagged or dropped.

---
 rtl/squid_burst_collector_if.sv | 66 ++++++
 rtl/squid_burst_collector.sv | 166 ++++++++++++++++
 tb/tb_squid_burst_collector.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/squid_burst_collector_if.sv
// ---------------------------------------------------------------------------
// squid_burst_collector_if
// Bus bundle between the memory-side burst source, the burst collector and
// the syndrome generator.
//
//   in_valid / in_ready / in_data / in_last : narrow beat stream into the
//                                             collector
//   out_valid / out_ready                   : codeword handshake toward the
//                                             decoder
//   out_weight                              : NUM_SYM data symbols,
//                                             symbol i at [SYM_W*i +: SYM_W]
//   out_parity                              : NUM_PAR parity nibbles,
//                                             nibble j at [PAR_W*j +: PAR_W]
//   out_frame_err                           : burst was too long (qualified
//                                             by out_valid)
//   drop_cnt                                : saturating count of discarded
//                                             short bursts
//
// Modports:
//   slave  - the collector itself
//   master - the surrounding environment (burst source plus decoder)
// ---------------------------------------------------------------------------
interface squid_burst_collector_if #(
    parameter int BEAT_W  = 8,
    parameter int NUM_SYM = 8,
    parameter int SYM_W   = 6,
    parameter int NUM_PAR = 4,
    parameter int PAR_W   = 4
);
    logic                       in_valid;
    logic                       in_ready;
    logic [BEAT_W-1:0]          in_data;
    logic                       in_last;
    logic                       out_valid;
    logic                       out_ready;
    logic [NUM_SYM*SYM_W-1:0]   out_weight;
    logic [NUM_PAR*PAR_W-1:0]   out_parity;
    logic                       out_frame_err;
    logic [7:0]                 drop_cnt;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_weight,
        output out_parity,
        output out_frame_err,
        output drop_cnt
    );

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_weight,
        input  out_parity,
        input  out_frame_err,
        input  drop_cnt
    );
endinterface

// File: rtl/squid_burst_collector.sv
// ---------------------------------------------------------------------------
// squid_burst_collector
// Assembles one SQUID codeword from a burst of BEATS narrow beats, splits it
// into data symbols and parity nibbles, and presents it through a one-entry
// output register with a valid/ready handshake. Short bursts are dropped and
// counted; overlong bursts are emitted from their first BEATS beats with
// out_frame_err set, the excess beats being discarded.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous reset, active high
//   bus  - squid_burst_collector_if.slave (beat stream in, codeword out,
//          frame error flag, drop counter)
//
// state   | meaning
// --------+-----------------------------------------------------------------
// COLLECT | accepting beats into the assembly register
// WAIT    | final beat parked in the stage, output register still occupied
// DRAIN   | frame already emitted, discarding beats up to in_last
// ---------------------------------------------------------------------------
module squid_burst_collector #(
    parameter int BEATS   = 8,
    parameter int BEAT_W  = 8,
    parameter int NUM_SYM = 8,
    parameter int SYM_W   = 6,
    parameter int NUM_PAR = 4,
    parameter int PAR_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    squid_burst_collector_if.slave     bus
);

    localparam int FRAME_W  = BEATS * BEAT_W;
    localparam int ASM_W    = (BEATS - 1) * BEAT_W;
    localparam int WEIGHT_W = NUM_SYM * SYM_W;
    localparam int PARITY_W = NUM_PAR * PAR_W;
    localparam int CNT_W    = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_WAIT    = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [ASM_W-1:0]       asm_q;
    logic [BEAT_W-1:0]      stage_q;
    logic                   stage_last_q;
    logic [FRAME_W-1:0]     out_frame_q;
    logic                   out_valid_q;
    logic                   out_err_q;
    logic [7:0]             drop_cnt_q;

    logic                   accept;
    logic                   out_free;
    logic                   load;
    logic [FRAME_W-1:0]     frame_d;
    logic                   err_d;

    // The output slot counts as free when it is empty or being popped this
    // cycle, which is what allows a load and a pop on the same edge.
    assign out_free = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && bus.in_ready;

    // Load source: the live final beat in COLLECT, the parked beat in WAIT.
    always_comb begin
        load    = 1'b0;
        frame_d = {bus.in_data, asm_q};
        err_d   = !bus.in_last;
        case (state_q)
            S_COLLECT: begin
                if (accept && (cnt_q == LAST_BEAT) && out_free) begin
                    load = 1'b1;
                end
            end
            S_WAIT: begin
                frame_d = {stage_q, asm_q};
                err_d   = !stage_last_q;
                if (out_free) begin
                    load = 1'b1;
                end
            end
            default: begin
                load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_COLLECT;
            cnt_q        <= '0;
            asm_q        <= '0;
            stage_q      <= '0;
            stage_last_q <= 1'b0;
            out_frame_q  <= '0;
            out_valid_q  <= 1'b0;
            out_err_q    <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            if (load) begin
                out_frame_q <= frame_d;
                out_valid_q <= 1'b1;
                out_err_q   <= err_d;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                S_COLLECT: begin
                    if (accept) begin
                        if (cnt_q != LAST_BEAT) begin
                            for (int b = 0; b < BEATS - 1; b++) begin
                                if (cnt_q == CNT_W'(b)) begin
                                    asm_q[b*BEAT_W +: BEAT_W] <= bus.in_data;
                                end
                            end
                            if (bus.in_last) begin
                                cnt_q <= '0;
                                if (drop_cnt_q != 8'hFF) begin
                                    drop_cnt_q <= drop_cnt_q + 8'd1;
                                end
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end else if (out_free) begin
                            cnt_q   <= '0;
                            state_q <= bus.in_last ? S_COLLECT : S_DRAIN;
                        end else begin
                            stage_q      <= bus.in_data;
                            stage_last_q <= bus.in_last;
                            state_q      <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (out_free) begin
                        cnt_q   <= '0;
                        state_q <= stage_last_q ? S_COLLECT : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (accept && bus.in_last) begin
                        state_q <= S_COLLECT;
                    end
                end
                default: begin
                    state_q <= S_COLLECT;
                end
            endcase
        end
    end

    // in_ready decodes state only, so a source may look at it before
    // deciding to raise in_valid.
    assign bus.in_ready      = (state_q != S_WAIT);
    assign bus.out_valid     = out_valid_q;
    assign bus.out_frame_err = out_err_q;
    assign bus.out_weight    = out_frame_q[WEIGHT_W-1:0];
    assign bus.out_parity    = out_frame_q[WEIGHT_W +: PARITY_W];
    assign bus.drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_squid_burst_collector.sv
module tb_squid_burst_collector;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    squid_burst_collector_if bus ();

    squid_burst_collector dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          total = 0;
    int          bad   = 0;
    int          exp_drop = 0;
    int          pops  = 0;
    int          stalls = 0;
    bit          rand_ready = 1'b0;
    logic [63:0] exp_q[$];
    logic        exp_err_q[$];
    logic [7:0]  bd[16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock step; inputs change 1 time unit after the rising edge.
    task automatic step();
        if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input bit last);
        int g = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (bus.in_ready !== 1'b1 && g < 60) begin
            stalls++;
            step();
            g++;
        end
        total++;
        assert (g < 60) else begin
            bad++;
            $error("FAIL beat_timeout: observed in_ready=%0b expected 1", bus.in_ready);
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    // Reference: first 8 beats form the frame (beat b at bits 8b+7:8b);
    // fewer than 8 beats is a drop, more than 8 flags a frame error.
    task automatic burst(input int len, input bit fixed);
        logic [63:0] f = '0;
        for (int i = 0; i < len; i++) if (!fixed) bd[i] = 8'($urandom);
        if (len < 8) begin
            exp_drop = (exp_drop >= 255) ? 255 : exp_drop + 1;
        end else begin
            for (int i = 0; i < 8; i++) f[8*i +: 8] = bd[i];
            exp_q.push_back(f);
            exp_err_q.push_back(len != 8);
        end
        for (int i = 0; i < len; i++) beat(bd[i], i == len - 1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"},  bus.in_ready, 1);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_frame_err"}, bus.out_frame_err, 0);
        chk({tag, "_drop_cnt"},  bus.drop_cnt, 0);
        chk({tag, "_weight"},    bus.out_weight, 0);
        chk({tag, "_parity"},    bus.out_parity, 0);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        exp_err_q.delete();
        exp_drop = 0;
    endtask

    // Output monitor: every visible codeword must match the model's head
    // entry (which also covers stability under back-pressure); pop on handshake.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.out_valid === 1'b1) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_frame: observed out_valid=1 expected no frame");
            end
            if (exp_q.size() != 0) begin
                chk("frame_weight", bus.out_weight, exp_q[0][47:0]);
                chk("frame_parity", bus.out_parity, exp_q[0][63:48]);
                chk("frame_err",    bus.out_frame_err, exp_err_q[0]);
                if (bus.out_ready === 1'b1) begin
                    void'(exp_q.pop_front());
                    void'(exp_err_q.pop_front());
                    pops++;
                end
            end
        end
    end

    initial begin
        int sym_exp[8];
        int par_exp[4];
        int p0;
        int g;
        sym_exp = '{3, 23, 1, 10, 14, 48, 60, 23};
        par_exp = '{13, 6, 12, 11};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_state("reset");

        // Nominal burst
        bd[0] = 8'hC3; bd[1] = 8'h15; bd[2] = 8'h28; bd[3] = 8'h0E;
        bd[4] = 8'hCC; bd[5] = 8'h5F; bd[6] = 8'h6D; bd[7] = 8'hBC;
        burst(8, 1'b1);
        chk("nom_valid", bus.out_valid, 1);
        chk("nom_err", bus.out_frame_err, 0);
        for (int i = 0; i < 8; i++) chk("nom_symbol", bus.out_weight[6*i +: 6], sym_exp[i]);
        for (int j = 0; j < 4; j++) chk("nom_parity", bus.out_parity[4*j +: 4], par_exp[j]);
        step();
        chk("nom_popped", bus.out_valid, 0);

        // Back-to-back bursts, no back-pressure
        stalls = 0;
        p0 = pops;
        for (int k = 0; k < 3; k++) begin
            burst(8, 1'b0);
            chk("b2b_valid", bus.out_valid, 1);
        end
        chk("b2b_no_stall", stalls, 0);
        step();
        chk("b2b_pops", pops - p0, 3);
        chk("b2b_idle", bus.out_valid, 0);

        // Back-pressure: second burst parks in WAIT
        bus.out_ready = 1'b0;
        p0 = pops;
        burst(8, 1'b0);
        chk("bp_first_valid", bus.out_valid, 1);
        burst(8, 1'b0);
        chk("bp_wait_ready", bus.in_ready, 0);
        step();
        step();
        chk("bp_wait_hold", bus.in_ready, 0);
        chk("bp_hold_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        step();
        chk("bp_release_ready", bus.in_ready, 1);
        chk("bp_second_valid", bus.out_valid, 1);
        chk("bp_first_popped", pops - p0, 1);
        step();
        chk("bp_second_popped", pops - p0, 2);

        // Short burst then a good one
        burst(4, 1'b0);
        chk("short_no_valid", bus.out_valid, 0);
        chk("short_drop", bus.drop_cnt, exp_drop);
        burst(8, 1'b0);
        chk("after_short_valid", bus.out_valid, 1);
        step();
        for (int k = 0; k < 300; k++) burst($urandom_range(1, 7), 1'b0);
        chk("drop_saturated", bus.drop_cnt, 255);
        chk("drop_model", bus.drop_cnt, exp_drop);

        // Long burst: 10 beats, then a normal burst
        p0 = pops;
        burst(10, 1'b0);
        chk("long_ready", bus.in_ready, 1);
        chk("long_one_frame", pops - p0, 1);
        burst(8, 1'b0);
        chk("after_long_valid", bus.out_valid, 1);
        step();

        // Reset after beat 4 of a burst
        for (int i = 0; i < 5; i++) beat(8'($urandom), 1'b0);
        do_reset();
        chk_reset_state("rst_mid");
        burst(8, 1'b0);
        chk("rst_mid_fresh_valid", bus.out_valid, 1);
        step();

        // Reset while in WAIT
        bus.out_ready = 1'b0;
        burst(8, 1'b0);
        burst(8, 1'b0);
        chk("rst_wait_in_wait", bus.in_ready, 0);
        do_reset();
        chk_reset_state("rst_wait");
        bus.out_ready = 1'b1;
        burst(8, 1'b0);
        chk("rst_wait_fresh_valid", bus.out_valid, 1);
        step();

        // Random mix of burst lengths with random back-pressure
        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            burst($urandom_range(1, 11), 1'b0);
            chk("rand_drop", bus.drop_cnt, exp_drop);
        end
        rand_ready = 1'b0;
        bus.out_ready = 1'b1;
        g = 0;
        while (exp_q.size() != 0 && g < 40) begin
            step();
            g++;
        end
        chk("rand_drained", exp_q.size(), 0);
        step();
        chk("rand_idle", bus.out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
